// File: rtl/team_06_i2s_pkg.sv
// Shared I2S definitions for the audio-path transmitter and the ADC receiver.
package team_06_i2s_pkg;

    localparam int DATA_W     = 8;
    localparam int SLOT_W     = 16;
    localparam int FRAME_BITS = 2 * SLOT_W;

    typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/team_06_i2s_tx_clkgen.sv
// I2S bit-clock divider: produces i2s_bclk and a strobe marking the clk cycle
// in which bclk is registered from 1 to 0.
module team_06_i2s_tx_clkgen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    output logic i2s_bclk,
    output logic fall
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             term;

    assign term = en && (div_cnt == DIV_LAST);
    assign fall = term && i2s_bclk;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (!en) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (term) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/team_06_i2s_transmitter.sv
// I2S transmitter: one-entry sample buffer with valid/ready intake; each mono
// sample is sent MSB first on both the left and right slots of a frame.
module team_06_i2s_transmitter #(
    parameter int DATA_W  = team_06_i2s_pkg::DATA_W,
    parameter int SLOT_W  = team_06_i2s_pkg::SLOT_W,
    parameter int CLK_DIV = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              mute,
    output logic              i2s_bclk,
    output logic              i2s_ws,
    output logic              i2s_sd,
    output logic              underrun
);

    import team_06_i2s_pkg::*;

    localparam int FRAME_LEN = 2 * SLOT_W;
    localparam int POS_W     = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0] WS_FIRST = POS_W'(SLOT_W - 1);
    localparam logic [POS_W-1:0] WS_LAST  = POS_W'(FRAME_LEN - 2);
    localparam logic [POS_W-1:0] SLOT_P   = POS_W'(SLOT_W);

    // Bit of the sample carried at a frame position; positions past the
    // sample inside a slot shift out to zero padding.
    function automatic logic slot_bit(input logic [DATA_W-1:0] a,
                                      input logic [POS_W-1:0]  p);
        logic [POS_W-1:0]  off;
        logic [DATA_W-1:0] sh;
        off = (p >= SLOT_P) ? p - SLOT_P : p;
        sh  = a << off;
        return sh[DATA_W-1];
    endfunction

    logic              fall;
    logic              frame_start;
    logic              take;
    logic              full;
    logic              full_next;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_next;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] active;
    logic [DATA_W-1:0] active_next;
    logic              ws_next;
    logic              sd_next;

    team_06_i2s_tx_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .i2s_bclk (i2s_bclk),
        .fall     (fall)
    );

    assign sample_ready = en && !full;

    always_comb begin
        frame_start = fall && (pos == POS_LAST);
        pos_next    = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
        take        = sample_valid && sample_ready;

        // mute zeroes the frame but still consumes the buffered sample
        active_next = active;
        if (frame_start) begin
            active_next = (full && !mute) ? buf_data : '0;
        end

        full_next = full;
        if (frame_start && full) begin
            full_next = 1'b0;
        end else if (take) begin
            full_next = 1'b1;
        end

        ws_next = (pos_next >= WS_FIRST) && (pos_next <= WS_LAST);
        sd_next = slot_bit(active_next, pos_next);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pos      <= POS_LAST;
            full     <= 1'b0;
            active   <= '0;
            i2s_ws   <= 1'b0;
            i2s_sd   <= 1'b0;
            underrun <= 1'b0;
        end else if (!en) begin
            pos      <= POS_LAST;
            full     <= 1'b0;
            active   <= '0;
            i2s_ws   <= 1'b0;
            i2s_sd   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            full     <= full_next;
            active   <= active_next;
            underrun <= frame_start && !full;
            if (fall) begin
                pos    <= pos_next;
                i2s_ws <= ws_next;
                i2s_sd <= sd_next;
            end
        end
    end

    // Buffer contents are only meaningful while full is set.
    always_ff @(posedge clk) begin
        if (take) begin
            buf_data <= sample_in;
        end
    end

endmodule

// File: tb/tb_team_06_i2s_transmitter.sv
// Directed bench for the I2S transmitter: walks frames bit by bit and checks
// ws/sd, underrun, handshake, mute, disable and asynchronous reset.
module tb_team_06_i2s_transmitter;

    localparam int CLK_DIV = 8;

    logic       clk;
    logic       nrst;
    logic       en;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       mute;
    logic       i2s_bclk;
    logic       i2s_ws;
    logic       i2s_sd;
    logic       underrun;

    int n_cmp = 0;
    int n_bad = 0;
    int ticks_since = 0;
    int gap = 0;
    logic fell = 1'b0;

    team_06_i2s_transmitter #(
        .DATA_W  (8),
        .SLOT_W  (16),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .i2s_bclk     (i2s_bclk),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic b0;
        b0 = i2s_bclk;
        @(posedge clk);
        #1;
        fell = (b0 === 1'b1) && (i2s_bclk === 1'b0);
        ticks_since++;
        if (fell) begin
            gap = ticks_since;
            ticks_since = 0;
        end
    endtask

    task automatic wait_fall();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * CLK_DIV && !seen; i++) begin
            tick();
            seen = fell;
        end
        chk("fall_seen", 8'(seen), 8'd1);
        if (seen) chk("fall_spacing", 8'(gap), 8'(CLK_DIV));
    endtask

    function automatic logic exp_ws(input int p);
        return (p >= 15) && (p <= 30);
    endfunction

    function automatic logic exp_sd(input int p, input logic [7:0] s);
        if (p < 8) return s[7-p];
        if (p >= 16 && p < 24) return s[23-p];
        return 1'b0;
    endfunction

    task automatic frame(input int first, input int last, input logic [7:0] s,
                         input logic ur, input logic rdy,
                         input logic reload, input logic [7:0] next_in);
        for (int p = first; p <= last; p++) begin
            wait_fall();
            chk($sformatf("ws_p%0d_s%0h", p, s), 8'(i2s_ws), 8'(exp_ws(p)));
            chk($sformatf("sd_p%0d_s%0h", p, s), 8'(i2s_sd), 8'(exp_sd(p, s)));
            if (p == 0) begin
                chk("underrun_at_start", 8'(underrun), 8'(ur));
                chk("ready_at_start", 8'(sample_ready), 8'(rdy));
                if (reload) begin
                    sample_in    = next_in;
                    sample_valid = 1'b1;
                    tick();
                    chk("ready_after_reload", 8'(sample_ready), 8'd0);
                    sample_valid = 1'b0;
                end
            end else begin
                chk("underrun_mid_frame", 8'(underrun), 8'd0);
            end
        end
    endtask

    initial begin
        nrst         = 1'b0;
        en           = 1'b1;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        mute         = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_bclk", 8'(i2s_bclk), 8'd0);
        chk("rst_ws", 8'(i2s_ws), 8'd0);
        chk("rst_sd", 8'(i2s_sd), 8'd0);
        chk("rst_underrun", 8'(underrun), 8'd0);
        chk("rst_ready", 8'(sample_ready), 8'd1);

        // first fall eight cycles after release, empty buffer -> underrun
        nrst = 1'b1;
        ticks_since = 0;
        repeat (7) tick();
        chk("bclk_high_before_first_fall", 8'(i2s_bclk), 8'd1);
        chk("no_underrun_before_first_fall", 8'(underrun), 8'd0);
        tick();
        chk("first_fall", 8'(fell), 8'd1);
        chk("first_fall_gap", 8'(gap), 8'd8);
        chk("first_underrun", 8'(underrun), 8'd1);
        chk("first_ws", 8'(i2s_ws), 8'd0);
        chk("first_sd", 8'(i2s_sd), 8'd0);
        tick();
        chk("underrun_one_cycle", 8'(underrun), 8'd0);
        frame(1, 31, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);

        // single 0xA5 sample
        sample_in    = 8'hA5;
        sample_valid = 1'b1;
        tick();
        chk("ready_drop_a5", 8'(sample_ready), 8'd0);
        sample_valid = 1'b0;
        frame(0, 31, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00);

        // valid held high: 0xFF then 0x01, one per frame
        sample_in    = 8'hFF;
        sample_valid = 1'b1;
        tick();
        chk("ready_drop_ff", 8'(sample_ready), 8'd0);
        sample_in = 8'h01;
        frame(0, 31, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("buffer_holds_01", 8'(sample_ready), 8'd0);
        frame(0, 31, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80);

        // muted frame consumes 0x80 without underrun
        mute = 1'b1;
        frame(0, 31, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        mute = 1'b0;
        sample_in    = 8'h80;
        sample_valid = 1'b1;
        tick();
        chk("ready_drop_80", 8'(sample_ready), 8'd0);
        sample_valid = 1'b0;
        frame(0, 31, 8'h80, 1'b0, 1'b1, 1'b0, 8'h00);

        // transfer in the same cycle as the frame-start fall
        repeat (7) tick();
        chk("bclk_high_pre_collision", 8'(i2s_bclk), 8'd1);
        sample_in    = 8'h3C;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("collision_fall", 8'(fell), 8'd1);
        chk("collision_underrun", 8'(underrun), 8'd1);
        chk("collision_ready", 8'(sample_ready), 8'd0);
        chk("collision_sd", 8'(i2s_sd), 8'd0);
        chk("collision_ws", 8'(i2s_ws), 8'd0);
        frame(1, 31, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        frame(0, 20, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h5A);

        // drop enable at pos 20 with 0x5A buffered
        repeat (3) tick();
        en = 1'b0;
        tick();
        chk("dis_bclk", 8'(i2s_bclk), 8'd0);
        chk("dis_ws", 8'(i2s_ws), 8'd0);
        chk("dis_sd", 8'(i2s_sd), 8'd0);
        chk("dis_underrun", 8'(underrun), 8'd0);
        chk("dis_ready", 8'(sample_ready), 8'd0);
        tick();
        en = 1'b1;
        ticks_since = 0;
        repeat (7) tick();
        chk("reen_bclk_high", 8'(i2s_bclk), 8'd1);
        tick();
        chk("reen_fall", 8'(fell), 8'd1);
        chk("reen_gap", 8'(gap), 8'd8);
        chk("reen_underrun", 8'(underrun), 8'd1);
        chk("reen_ready", 8'(sample_ready), 8'd1);
        chk("reen_sd", 8'(i2s_sd), 8'd0);
        frame(1, 15, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);

        // asynchronous reset while ws is high
        nrst = 1'b0;
        #2;
        chk("arst_ws", 8'(i2s_ws), 8'd0);
        chk("arst_bclk", 8'(i2s_bclk), 8'd0);
        chk("arst_sd", 8'(i2s_sd), 8'd0);
        chk("arst_ready", 8'(sample_ready), 8'd1);
        nrst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/team_06_i2s_transmitter.md
Name: team_06_i2s_transmitter

Overview:
Serializes 8-bit processed audio samples onto a standard I2S link (bclk, ws, sd) driving the speaker DAC. It is the transmit counterpart of the ADC I2S receiver in the audio path and is fed by the audio-effect or FSM output stage through a valid/ready handshake. A one-entry holding buffer decouples the sample producer from frame timing. Each mono sample is played on both the left and right channels.

Parameters:
DATA_W, 8, sample width in bits; sent MSB first.
SLOT_W, 16, bclk periods per channel slot; must be >= DATA_W. Bits after the sample are zero padding.
CLK_DIV, 8, clk cycles per bclk period; must be even and >= 2.

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
en  input  1  block enable
sample_in  input  DATA_W  sample from upstream
sample_valid  input  1  sample_in is valid
sample_ready  output  1  holding buffer can accept a sample
mute  input  1  forces silence for frames that start while mute is high
i2s_bclk  output  1  I2S bit clock
i2s_ws  output  1  word select; 0 = left, 1 = right
i2s_sd  output  1  serial data
underrun  output  1  one-clk pulse when a frame starts with the buffer empty

Behaviour:
- Reset (nrst=0, asynchronous): all of the following are forced immediately.
  - i2s_bclk=0, i2s_ws=0, i2s_sd=0, underrun=0.
  - sample_ready=1. Holding buffer empty.
  - div_cnt=0. Frame position pos = 2*SLOT_W-1. Active sample register = 0.
- en=0: synchronously returns to the reset state, except sample_ready=0. Any buffered sample is discarded. The same behaviour applies when en drops mid-frame.
- Bit clock:
  - div_cnt counts 0..CLK_DIV/2-1 while en=1.
  - At the terminal count, i2s_bclk toggles and div_cnt wraps to 0.
  - A "fall" event is the clk cycle in which bclk is registered 1->0.
  - The first fall occurs CLK_DIV clk cycles after en/nrst release.
- Frame position:
  - pos increments on each fall.
  - It wraps from 2*SLOT_W-1 to 0. That wrap is the frame start.
- Registered outputs:
  - i2s_ws and i2s_sd update only on fall cycles, in the same cycle bclk goes low.
  - The DAC samples them on the bclk rising edge.
- ws timing (one-bit I2S lead):
  - i2s_ws=1 for pos in SLOT_W-1..2*SLOT_W-2.
  - i2s_ws=0 otherwise.
- sd mapping, where A is the active sample:
  - pos 0..DATA_W-1 carries A[DATA_W-1-pos] (left channel).
  - pos SLOT_W..SLOT_W+DATA_W-1 carries A[DATA_W-1-(pos-SLOT_W)] (right channel).
  - All other positions carry 0.
- Frame start (fall into pos 0):
  - If the buffer is full: A <= buffer, or 0 if mute=1. The buffer empties. i2s_sd takes the new A[MSB] on this same fall.
  - If the buffer is empty: A <= 0 and underrun pulses high for exactly that clk cycle.
  - mute never suppresses consumption of the buffer. A muted full buffer does not raise underrun.
- Handshake:
  - sample_ready = en and buffer empty.
  - A transfer occurs on a rising clk edge with sample_valid && sample_ready. The buffer latches sample_in and becomes full.
  - While full, sample_ready=0 and sample_in is ignored.
  - If a transfer and a frame start fall in the same cycle, the frame consumes the old (empty) state and raises underrun. The new sample is held for the next frame.
  - The producer may hold sample_valid high indefinitely. Exactly one sample is taken per frame.
- Throughput: one sample per 2*SLOT_W*CLK_DIV clk cycles, i.e. 256 with the defaults.
- No arithmetic is performed: bits pass through unchanged, so sign interpretation is left to the DAC.

Decomposition:
- Package team_06_i2s_pkg holds:
  - the DATA_W and SLOT_W defaults;
  - a localparam FRAME_BITS = 2*SLOT_W;
  - the typedef sample_t (logic [DATA_W-1:0]).
- The package is shared with the ADC receiver.
- Sub-module team_06_i2s_tx_clkgen holds div_cnt and the bclk register, and outputs i2s_bclk and a one-cycle fall strobe.
- The top level holds pos, ws/sd generation, the holding buffer and the handshake.

Test Plan:
1. Release reset with en=1 and no samples.
   -> First fall at clk cycle 8. Each frame start pulses underrun. sd is constantly 0. ws is low for pos 31 and 0..14, high for pos 15..30.
2. Present sample_in=0xA5 with valid before the first fall.
   -> Ready drops the next cycle. At pos 0..7, sd = 1,0,1,0,0,1,0,1. Pos 8..15 = 0. Pos 16..23 repeat 1,0,1,0,0,1,0,1. No underrun. Ready returns to 1 on the frame-start cycle.
3. Hold sample_valid high continuously with 0xFF then 0x01.
   -> Exactly one sample is accepted per 256-cycle frame. The frames show 0xFF then 0x01 in order, with no underrun.
4. Buffer 0x80 with mute=1 at the frame start.
   -> Both channels are all-zero, the buffer is consumed (ready=1), and underrun stays 0. The next frame with mute=0 and sample 0x80 shows sd=1 only at pos 0 and pos 16.
5. Raise sample_valid in the same cycle as a frame-start fall, with the buffer empty.
   -> underrun pulses. The sample appears in the following frame.
6. Drop en or nrst mid-frame at pos 20 with a sample buffered.
   -> The reset state is restored: bclk/ws/sd = 0. On re-enable, the buffer is empty and timing restarts with the first fall after 8 cycles.
